// File: rtl/axo_mem_sram_if.sv
`default_nettype none
// ============================================================================
// Module   : axo_mem_bus
// Brief    : Request/response memory bus between a requester and one memory.
// Revision : 1.0 - initial release
// ============================================================================
interface axo_mem_bus #(
    parameter int DLEN = 32,
    parameter int ALEN = 32
);
    logic            re;
    logic            we;
    logic [2:0]      asize;
    logic [ALEN-1:0] addr;
    logic [DLEN-1:0] wdata;
    logic            ready;
    logic            error;
    logic [DLEN-1:0] rdata;

    modport MEM (input re, we, asize, addr, wdata, output ready, error, rdata);
    modport CPU (output re, we, asize, addr, wdata, input ready, error, rdata);
endinterface
`default_nettype wire

// File: rtl/axo_mem_sram.sv
`default_nettype none
// ============================================================================
// Module   : axo_mem_sram
// Brief    : Single-port synchronous SRAM terminating an axo_mem_bus, with
//            programmable wait states, byte-lane masking and error responses.
//            Optional write protect input: define AXO_MEM_SRAM_WPROT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`ifndef AXO_MEM_EALIGN
`define AXO_MEM_EALIGN 32'hEA11_0001
`endif
`ifndef AXO_MEM_EWPROT
`define AXO_MEM_EWPROT 32'hEA11_0002
`endif

module axo_mem_sram #(
    parameter int DLEN        = 32,
    parameter int ALEN        = 32,
    parameter int DEPTH_LOG2  = 12,
    parameter int WAIT_CYCLES = 0
) (
    input  logic      clk,
    input  logic      rst,
    axo_mem_bus.MEM   bus
`ifdef AXO_MEM_SRAM_WPROT_EN
    ,
    input  logic      wprot
`endif
);

    localparam int c_nbytes = DLEN / 8;
    localparam int c_lb     = $clog2(c_nbytes);
    localparam int c_iw     = DEPTH_LOG2 - c_lb;
    localparam int c_words  = 1 << c_iw;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              r_state, w_state_next;
    logic [3:0]          r_cnt, w_cnt_next;
    logic [c_iw-1:0]     r_idx, w_idx_live, w_rd_idx;
    logic [c_nbytes-1:0] r_be, w_be_live;
    logic [DLEN-1:0]     r_wdata, r_code, w_code_live, w_cur_code;
    logic                r_we, r_err, w_err_live, w_cur_we, w_cur_err;
    logic                r_ready, r_error;
    logic [DLEN-1:0]     r_rdata;
    logic                w_req, w_capture, w_enter_resp, w_commit;
    logic                w_misal, w_too_big;
    logic [ALEN-1:0]     w_amask;
    logic [c_lb-1:0]     w_off;
    logic [DLEN-1:0]     r_mem [0:c_words-1];

    assign w_req      = bus.re | bus.we;
    assign w_capture  = (r_state == S_IDLE) && w_req;
    assign w_idx_live = bus.addr[DEPTH_LOG2-1:c_lb];
    assign w_off      = bus.addr[c_lb-1:0];
    assign w_amask    = (ALEN'(1) << bus.asize) - ALEN'(1);
    assign w_misal    = |(bus.addr & w_amask);
    assign w_too_big  = 32'(bus.asize) > 32'(c_lb);

`ifdef AXO_MEM_SRAM_WPROT_EN
    assign w_err_live  = w_misal | w_too_big | (bus.re & bus.we) | (bus.we & wprot);
    assign w_code_live = (w_misal | w_too_big | (bus.re & bus.we)) ?
                         DLEN'(`AXO_MEM_EALIGN) : DLEN'(`AXO_MEM_EWPROT);
`else
    assign w_err_live  = w_misal | w_too_big | (bus.re & bus.we);
    assign w_code_live = DLEN'(`AXO_MEM_EALIGN);
`endif

    // Lanes covered by the access; only meaningful when aligned and in range.
    always_comb begin
        w_be_live = '0;
        for (int k = 0; k < c_nbytes; k++) begin
            w_be_live[k] = (k >= int'(w_off)) && (k < int'(w_off) + (1 << bus.asize));
        end
    end

    // When entering RESP straight from IDLE the capture registers are not yet loaded.
    assign w_rd_idx   = (r_state == S_IDLE) ? w_idx_live  : r_idx;
    assign w_cur_we   = (r_state == S_IDLE) ? bus.we      : r_we;
    assign w_cur_err  = (r_state == S_IDLE) ? w_err_live  : r_err;
    assign w_cur_code = (r_state == S_IDLE) ? w_code_live : r_code;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_enter_resp = 1'b0;
        w_commit     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    if (WAIT_CYCLES == 0) begin
                        w_state_next = S_RESP;
                        w_enter_resp = 1'b1;
                    end else begin
                        w_state_next = S_WAIT;
                        w_cnt_next   = 4'(WAIT_CYCLES);
                    end
                end
            end
            S_WAIT: begin
                if (!w_req) begin
                    w_state_next = S_IDLE;
                    w_cnt_next   = 4'd0;
                end else if (r_cnt <= 4'd1) begin
                    w_state_next = S_RESP;
                    w_cnt_next   = 4'd0;
                    w_enter_resp = 1'b1;
                end else begin
                    w_cnt_next   = r_cnt - 4'd1;
                end
            end
            S_RESP: begin
                w_state_next = S_IDLE;
                w_commit     = w_req && r_we && !r_err;
            end
            default: begin
                w_state_next = S_IDLE;
                w_cnt_next   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_idx   <= '0;
            r_be    <= '0;
            r_wdata <= '0;
            r_code  <= '0;
            r_we    <= 1'b0;
            r_err   <= 1'b0;
            r_ready <= 1'b0;
            r_error <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            if (w_capture) begin
                r_idx   <= w_idx_live;
                r_be    <= w_be_live;
                r_wdata <= bus.wdata;
                r_code  <= w_code_live;
                r_we    <= bus.we;
                r_err   <= w_err_live;
            end
            r_ready <= w_enter_resp;
            r_error <= w_enter_resp && w_cur_err;
            if (!w_enter_resp || w_cur_we) begin
                r_rdata <= w_cur_err && w_enter_resp ? w_cur_code : '0;
            end else begin
                r_rdata <= w_cur_err ? w_cur_code : r_mem[w_rd_idx];
            end
        end
    end

    // Contents are deliberately not reset; a reset during RESP drops the write.
    always_ff @(posedge clk) begin
        if (w_commit && !rst) begin
            for (int k = 0; k < c_nbytes; k++) begin
                if (r_be[k]) begin
                    r_mem[r_idx][8*k +: 8] <= r_wdata[8*k +: 8];
                end
            end
        end
    end

    assign bus.ready = r_ready;
    assign bus.error = r_error;
    assign bus.rdata = r_rdata;

endmodule
`default_nettype wire
